seq_restoring_divider32: RTL

SEQ_RESTORING_DIVIDER32 -- requirements
Module: seq_restoring_divider32

---
 rtl/seq_restoring_divider32.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider32.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider32
// Unsigned sequential restoring divider. Each accepted operand pair takes
// WIDTH cycles: one quotient bit is produced per cycle, MSB first. A zero
// divisor short-circuits straight to the result state with a saturated
// quotient and the dividend passed through as the remainder.
// Handshake: in_valid/in_ready on the operand side, out_valid/out_ready on
// the result side. Results are held in dedicated registers, so the outputs
// stay stable while the next division is being computed.
// ---------------------------------------------------------------------------
module seq_restoring_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Step counter is wide enough to hold WIDTH itself, so it never wraps
    // within a single operation.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Control state
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Working registers for the iteration in progress
    logic [WIDTH:0]   rem_q,   rem_d;
    logic [WIDTH-1:0] quo_q,   quo_d;
    logic [WIDTH-1:0] dvd_q,   dvd_d;
    logic [WIDTH-1:0] dvs_q,   dvs_d;

    // Presented result, only touched when an operation completes
    logic [WIDTH-1:0] res_quo_q, res_quo_d;
    logic [WIDTH-1:0] res_rem_q, res_rem_d;
    logic             dbz_q,     dbz_d;

    // Datapath for one restoring step
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             last_step;
    logic             accept;

    // The partial remainder is always below the divisor after a step, so
    // its top bit is zero going into the next shift; it only exists to
    // absorb the carry out of the shift before the trial subtraction.
    logic             unused_rem_msb;

    // Shift in the next dividend bit and try subtracting the divisor; the
    // top bit of the WIDTH+1 wide difference is the borrow.
    always_comb begin
        shifted  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        borrow   = trial[WIDTH];
        step_rem = borrow ? shifted : trial;
        step_quo = {quo_q[WIDTH-2:0], ~borrow};
    end

    assign unused_rem_msb = rem_q[WIDTH] ^ step_rem[WIDTH];

    assign last_step = (cnt_q == LAST_STEP);
    assign accept    = in_valid && (state_q == ST_IDLE);

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign quotient    = res_quo_q;
    assign remainder   = res_rem_q;
    assign div_by_zero = dbz_q;

    // Next-state logic: operand capture, iteration, completion, release
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        res_quo_d = res_quo_q;
        res_rem_d = res_rem_q;
        dbz_d     = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    if (divisor == '0) begin
                        // No iteration needed: publish the saturated result now
                        res_quo_d = '1;
                        res_rem_d = dividend;
                        dbz_d     = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_BUSY;
                    end
                end
            end

            ST_BUSY: begin
                rem_d = step_rem;
                quo_d = step_quo;
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    res_quo_d = step_quo;
                    res_rem_d = step_rem[WIDTH-1:0];
                    dbz_d     = 1'b0;
                    state_d   = ST_DONE;
                end
            end

            ST_DONE: begin
                // in_valid is deliberately ignored here; the consumer must
                // take the result before a new operation can start.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Working datapath registers, cleared on reset so nothing is ever X
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
        end
    end

    // Result registers; reset clears the visible outputs immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_quo_q <= '0;
            res_rem_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            res_quo_q <= res_quo_d;
            res_rem_q <= res_rem_d;
            dbz_q     <= dbz_d;
        end
    end

endmodule
